// File: rtl/gray_checker.sv
// Monitor for the upstream Gray counter: tracks binary value, laps and errors.
// Optional overflow cross-check enabled by defining OVF_CHECK_EN.
module gray_checker #(
  parameter int WIDTH = 3,
  parameter int LAP_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Step,
  input  logic [WIDTH-1:0] GrayIn,
  input  logic             OvfIn,
  output logic [WIDTH-1:0] Bin,
  output logic [LAP_W-1:0] Laps,
  output logic             Error,
  output logic [2:0]       ErrCode
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [2:0] E_STALL = 3'b001;
  localparam logic [2:0] E_MULTI = 3'b010;
  localparam logic [2:0] E_WRONG = 3'b011;
  localparam logic [2:0] E_OVF   = 3'b100;
  localparam logic [2:0] E_START = 3'b101;

  state_t           state, state_n;
  logic             step_q;
  logic [WIDTH-1:0] prev, prev_n;
  logic [WIDTH-1:0] bin, bin_n;
  logic [LAP_W-1:0] laps, laps_n;
  logic             err, err_n;
  logic [2:0]       code, code_n;

  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] gbin;
  logic [WIDTH-1:0] bin_inc;
  logic             multi;
  logic             wrap;
  logic             ovf_bad;

  function automatic logic [WIDTH-1:0] gray2bin(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic more_than_one(
    input logic [WIDTH-1:0] v
  );
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) n++;
    return n > 1;
  endfunction

  // Transition analysis of the sampled Gray code against the last accepted one
  always_comb begin
    delta   = GrayIn ^ prev;
    gbin    = gray2bin(GrayIn);
    bin_inc = bin + WIDTH'(1);
    multi   = more_than_one(delta);
    wrap    = step_q && (bin == '1);
  end

`ifdef OVF_CHECK_EN
  // Upstream overflow must be high once any wrap has happened or on this wrap
  always_comb begin
    ovf_bad = OvfIn != ((laps != '0) || wrap);
  end
`else
  logic unused_ovf;
  // Overflow input is not cross-checked in this build
  always_comb begin
    ovf_bad    = 1'b0;
    unused_ovf = OvfIn;
  end
`endif

  // Next-state and datapath updates; first failing check wins
  always_comb begin
    state_n = state;
    prev_n  = prev;
    bin_n   = bin;
    laps_n  = laps;
    err_n   = err;
    code_n  = code;
    case (state)
      IDLE: begin
        if (GrayIn != '0) begin
          state_n = ERROR;
          err_n   = 1'b1;
          code_n  = E_START;
        end else begin
          prev_n  = '0;
          bin_n   = '0;
          state_n = TRACK;
        end
      end
      TRACK: begin
        if (!step_q && delta != '0) begin
          state_n = ERROR;
          err_n   = 1'b1;
          code_n  = E_STALL;
        end else if (multi) begin
          state_n = ERROR;
          err_n   = 1'b1;
          code_n  = E_MULTI;
        end else if (step_q && gbin != bin_inc) begin
          state_n = ERROR;
          err_n   = 1'b1;
          code_n  = E_WRONG;
        end else if (ovf_bad) begin
          state_n = ERROR;
          err_n   = 1'b1;
          code_n  = E_OVF;
        end else begin
          prev_n = GrayIn;
          bin_n  = gbin;
          if (wrap && laps != '1)
            laps_n = laps + LAP_W'(1);
        end
      end
      default: begin
        state_n = ERROR;
      end
    endcase
  end

  // State register with synchronous active-high reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      step_q <= 1'b0;
      prev   <= '0;
      bin    <= '0;
      laps   <= '0;
      err    <= 1'b0;
      code   <= 3'b000;
    end else begin
      state  <= state_n;
      step_q <= Step;
      prev   <= prev_n;
      bin    <= bin_n;
      laps   <= laps_n;
      err    <= err_n;
      code   <= code_n;
    end
  end

  assign Bin     = bin;
  assign Laps    = laps;
  assign Error   = err;
  assign ErrCode = code;

endmodule

// File: tb/tb_gray_checker.sv
// Directed bench for gray_checker: tracking, error codes, reset, saturation.
// Expected codes follow OVF_CHECK_EN when it is defined for the build.
module tb_gray_checker;

  logic       Clk;
  logic       Reset;
  logic       Step;
  logic [2:0] GrayIn;
  logic       OvfIn;
  logic [2:0] Bin;
  logic [3:0] Laps;
  logic       Error;
  logic [2:0] ErrCode;

  int checks;
  int errors;

  gray_checker #(.WIDTH(3), .LAP_W(4)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Step    (Step),
    .GrayIn  (GrayIn),
    .OvfIn   (OvfIn),
    .Bin     (Bin),
    .Laps    (Laps),
    .Error   (Error),
    .ErrCode (ErrCode)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [2:0] b2g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic cyc(input logic s, input logic [2:0] g, input logic o);
    Step   = s;
    GrayIn = g;
    OvfIn  = o;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    Reset  = 1'b1;
    Step   = 1'b0;
    GrayIn = 3'b000;
    OvfIn  = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(2);
    checks++;
    if ({Bin, Laps, Error, ErrCode} !== 11'd0) begin
      errors++;
      $display("FAIL reset: got bin=%0d laps=%0d err=%0b code=%0d, want all 0",
               Bin, Laps, Error, ErrCode);
    end
  endtask

  task automatic test_count;
    logic [2:0] cnt;
    logic       ovf;
    logic [2:0] exp_bin [9];
    exp_bin = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    do_reset(1);
    cnt = 3'd0;
    ovf = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cyc(1'b1, b2g(cnt), ovf);
      if (cnt == 3'd7) ovf = 1'b1;
      cnt = cnt + 3'd1;
      checks++;
      if (Bin !== exp_bin[k] || Error !== 1'b0) begin
        errors++;
        $display("FAIL count[%0d]: got bin=%0d err=%0b, want bin=%0d err=0",
                 k, Bin, Error, exp_bin[k]);
      end
    end
    checks++;
    if (Laps !== 4'd1) begin
      errors++;
      $display("FAIL count_laps: got %0d, want 1", Laps);
    end
    cyc(1'b0, b2g(cnt), ovf);
    checks++;
    if (Bin !== 3'd1 || Error !== 1'b0) begin
      errors++;
      $display("FAIL count_post: got bin=%0d err=%0b, want 1 0", Bin, Error);
    end
  endtask

  task automatic test_stall_change;
    do_reset(1);
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b0, 3'b001, 1'b0);
    cyc(1'b0, 3'b011, 1'b0);
    checks++;
    if (Error !== 1'b1 || ErrCode !== 3'b001 || Bin !== 3'd1) begin
      errors++;
      $display("FAIL stall: got err=%0b code=%0d bin=%0d, want 1 1 1",
               Error, ErrCode, Bin);
    end
    cyc(1'b1, 3'b110, 1'b1);
    cyc(1'b0, 3'b000, 1'b0);
    checks++;
    if (Error !== 1'b1 || ErrCode !== 3'b001 || Bin !== 3'd1) begin
      errors++;
      $display("FAIL frozen: got err=%0b code=%0d bin=%0d, want 1 1 1",
               Error, ErrCode, Bin);
    end
  endtask

  task automatic test_multi_wrong;
    do_reset(1);
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b1, 3'b011, 1'b0);
    checks++;
    if (Error !== 1'b1 || ErrCode !== 3'b010 || Bin !== 3'd0) begin
      errors++;
      $display("FAIL multi: got err=%0b code=%0d bin=%0d, want 1 2 0",
               Error, ErrCode, Bin);
    end
    do_reset(1);
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b0, 3'b000, 1'b0);
    checks++;
    if (Error !== 1'b1 || ErrCode !== 3'b011) begin
      errors++;
      $display("FAIL no_advance: got err=%0b code=%0d, want 1 3",
               Error, ErrCode);
    end
    do_reset(1);
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b0, 3'b000, 1'b0);
    checks++;
    if (Error !== 1'b1 || ErrCode !== 3'b011 || Bin !== 3'd1) begin
      errors++;
      $display("FAIL backward: got err=%0b code=%0d bin=%0d, want 1 3 1",
               Error, ErrCode, Bin);
    end
  endtask

  task automatic test_bad_start;
    do_reset(1);
    cyc(1'b0, 3'b010, 1'b0);
    checks++;
    if (Error !== 1'b1 || ErrCode !== 3'b101) begin
      errors++;
      $display("FAIL bad_start: got err=%0b code=%0d, want 1 5",
               Error, ErrCode);
    end
  endtask

  task automatic test_reset_from_error;
    do_reset(1);
    cyc(1'b0, 3'b000, 1'b0);
    cyc(1'b0, 3'b001, 1'b0);
    checks++;
    if (Error !== 1'b1 || ErrCode !== 3'b001) begin
      errors++;
      $display("FAIL pre_reset: got err=%0b code=%0d, want 1 1",
               Error, ErrCode);
    end
    do_reset(1);
    checks++;
    if ({Bin, Laps, Error, ErrCode} !== 11'd0) begin
      errors++;
      $display("FAIL err_reset: got bin=%0d laps=%0d err=%0b code=%0d, want 0",
               Bin, Laps, Error, ErrCode);
    end
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b0, 3'b011, 1'b0);
    checks++;
    if (Bin !== 3'd2 || Error !== 1'b0) begin
      errors++;
      $display("FAIL resume: got bin=%0d err=%0b, want 2 0", Bin, Error);
    end
  endtask

  task automatic test_ovf;
    logic       exp_err;
    logic [2:0] exp_code;
`ifdef OVF_CHECK_EN
    exp_err  = 1'b1;
    exp_code = 3'b100;
`else
    exp_err  = 1'b0;
    exp_code = 3'b000;
`endif
    do_reset(1);
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b0, 3'b001, 1'b1);
    checks++;
    if (Error !== exp_err || ErrCode !== exp_code) begin
      errors++;
      $display("FAIL ovf: got err=%0b code=%0d, want %0b %0d",
               Error, ErrCode, exp_err, exp_code);
    end
  endtask

  task automatic test_saturate;
    logic [2:0] cnt;
    logic       ovf;
    do_reset(1);
    cyc(1'b1, 3'b000, 1'b0);
    cnt = 3'd1;
    ovf = 1'b0;
    for (int k = 0; k < 160; k++) begin
      cyc(1'b1, b2g(cnt), ovf);
      if (cnt == 3'd7) ovf = 1'b1;
      cnt = cnt + 3'd1;
      if (k == 119) begin
        checks++;
        if (Laps !== 4'd15) begin
          errors++;
          $display("FAIL laps15: got %0d, want 15", Laps);
        end
      end
    end
    checks++;
    if (Laps !== 4'd15 || Error !== 1'b0 || Bin !== 3'd0) begin
      errors++;
      $display("FAIL saturate: got laps=%0d err=%0b bin=%0d, want 15 0 0",
               Laps, Error, Bin);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    Step   = 1'b0;
    GrayIn = 3'b000;
    OvfIn  = 1'b0;
    test_reset;
    test_count;
    test_stall_change;
    test_multi_wrong;
    test_bad_start;
    test_reset_from_error;
    test_ovf;
    test_saturate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
